// File: rtl/ann_pkg.sv
// Shared types and helpers for the time-multiplexed ANN layer engine (ann_layer_seq).
package ann_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Flat register-file address of weight i of neuron o; i == n_in selects the bias.
   function automatic int unsigned wt_addr(input int unsigned o, input int unsigned i,
                                           input int unsigned n_in);
      return o * (n_in + 1) + i;
   endfunction

endpackage

// File: rtl/ann_mac.sv
// One signed multiply-accumulate step; ANN_LAYER_SAT_EN selects a saturating
// accumulator, otherwise the sum wraps at AW bits.
module ann_mac
   import ann_pkg::*;
#(
   parameter int DW = 3,
   parameter int WW = 4,
   parameter int AW = 8
) (
   input  logic [AW-1:0] acc_i,
   input  logic [WW-1:0] w_i,
   input  logic [DW-1:0] x_i,
   output logic [AW-1:0] acc_o
);

   localparam int PW = DW + WW;

   logic [PW-1:0] prod;
   logic [AW-1:0] prod_ext;

   // Low PW bits of the unsigned product of sign-extended operands equal the signed product.
   assign prod     = {{WW{x_i[DW-1]}}, x_i} * {{DW{w_i[WW-1]}}, w_i};
   assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};

`ifdef ANN_LAYER_SAT_EN
   logic [AW:0] sum;

   assign sum = {acc_i[AW-1], acc_i} + {prod_ext[AW-1], prod_ext};

   always_comb begin
      acc_o = sum[AW-1:0];
      if (sum[AW] != sum[AW-1]) begin
         acc_o = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end
   end
`else
   assign acc_o = acc_i + prod_ext;
`endif

endmodule

// File: rtl/ann_layer_seq.sv
// Fully-connected ANN layer, one MAC per cycle, ReLU outputs, valid/ready chaining.
// Saturating accumulation is built when ANN_LAYER_SAT_EN is defined.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | ready for a vector; weight/bias writes accepted
//   ST_MAC  | one product per cycle, neuron by neuron
//   ST_DONE | out_vec valid and held until out_ready
module ann_layer_seq
   import ann_pkg::*;
#(
   parameter int N_IN  = 6,
   parameter int N_OUT = 3,
   parameter int DW    = 3,
   parameter int WW    = 4,
   parameter int AW    = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               wr_en,
   input  logic [$clog2(N_OUT*(N_IN+1))-1:0]  wr_addr,
   input  logic [WW-1:0]                      wr_data,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [N_IN*DW-1:0]                 in_vec,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [N_OUT*AW-1:0]                out_vec,
   output logic                               busy
);

   localparam int NW  = N_OUT * (N_IN + 1);
   localparam int ADW = $clog2(NW);
   localparam int IW  = cnt_w(N_IN);
   localparam int OW  = cnt_w(N_OUT);

   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [OW-1:0]  neuron_q, neuron_d, neuron_inc;
   logic [AW-1:0]  acc_q, acc_d, mac_sum, relu_val;
   logic [DW-1:0]  x_q [N_IN];
   logic [WW-1:0]  w_q [NW];
   logic [AW-1:0]  out_q [N_OUT];
   logic [ADW-1:0] rd_addr, bias0_addr, bias_nxt_addr;
   logic [WW-1:0]  bias0_w, bias_nxt_w;
   logic           wr_ok, cap_en, out_we, last_idx, last_neuron;

   assign last_idx    = (idx_q == IW'(N_IN - 1));
   assign last_neuron = (neuron_q == OW'(N_OUT - 1));
   // Wraps to 0 on the last neuron so the bias lookup below never leaves the array.
   assign neuron_inc  = last_neuron ? '0 : neuron_q + OW'(1);

   assign rd_addr       = ADW'(wt_addr(32'(neuron_q), 32'(idx_q), N_IN));
   assign bias0_addr    = ADW'(wt_addr(0, N_IN, N_IN));
   assign bias_nxt_addr = ADW'(wt_addr(32'(neuron_inc), N_IN, N_IN));
   assign bias0_w       = w_q[bias0_addr];
   assign bias_nxt_w    = w_q[bias_nxt_addr];

   ann_mac #(.DW(DW), .WW(WW), .AW(AW)) u_mac (
      .acc_i (acc_q),
      .w_i   (w_q[rd_addr]),
      .x_i   (x_q[idx_q]),
      .acc_o (mac_sum)
   );

   assign relu_val = mac_sum[AW-1] ? '0 : mac_sum;
   assign wr_ok    = wr_en && (state_q == ST_IDLE) && ({1'b0, wr_addr} < (ADW+1)'(NW));

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      neuron_d = neuron_q;
      acc_d    = acc_q;
      cap_en   = 1'b0;
      out_we   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               cap_en   = 1'b1;
               idx_d    = '0;
               neuron_d = '0;
               acc_d    = {{(AW-WW){bias0_w[WW-1]}}, bias0_w};
               state_d  = ST_MAC;
            end
         end
         ST_MAC: begin
            if (last_idx) begin
               out_we   = 1'b1;
               idx_d    = '0;
               neuron_d = neuron_inc;
               acc_d    = {{(AW-WW){bias_nxt_w[WW-1]}}, bias_nxt_w};
               if (last_neuron) state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IW'(1);
               acc_d = mac_sum;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         neuron_q <= '0;
         acc_q    <= '0;
         for (int i = 0; i < N_IN; i++)  x_q[i]   <= '0;
         for (int i = 0; i < NW; i++)    w_q[i]   <= '0;
         for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         neuron_q <= neuron_d;
         acc_q    <= acc_d;
         if (cap_en) begin
            for (int i = 0; i < N_IN; i++) x_q[i] <= in_vec[i*DW +: DW];
         end
         if (wr_ok)  w_q[wr_addr]    <= wr_data;
         if (out_we) out_q[neuron_q] <= relu_val;
      end
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      assign out_vec[k*AW +: AW] = out_q[k];
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ann_layer_seq.sv
// Self-checking bench for ann_layer_seq: directed table, multi-cycle corner sequences,
// and randomized vectors against an arithmetic reference model.
module tb_ann_layer_seq;

   localparam int N_IN  = 6;
   localparam int N_OUT = 3;
   localparam int DW    = 3;
   localparam int WW    = 4;
   localparam int AW    = 8;
   localparam int NW    = N_OUT * (N_IN + 1);
   localparam int ADW   = $clog2(NW);
   localparam int LAT   = N_OUT * N_IN + 1;

   logic                clk = 1'b0;
   logic                rst, wr_en, in_valid, in_ready, out_valid, out_ready, busy;
   logic [ADW-1:0]      wr_addr;
   logic [WW-1:0]       wr_data;
   logic [N_IN*DW-1:0]  in_vec;
   logic [N_OUT*AW-1:0] out_vec;

   int errors = 0;
   int checks = 0;
   int wm [N_OUT][N_IN+1];

   typedef struct {
      int                  x [N_IN];
      logic [N_OUT*AW-1:0] exp;
   } vec_t;

   vec_t tbl [4];

   always #5 clk = ~clk;

   ann_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .busy      (busy)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: each accumulate step either clamps or wraps to AW bits.
   function automatic int step(input int v);
`ifdef ANN_LAYER_SAT_EN
      if (v > (1 << (AW-1)) - 1) return (1 << (AW-1)) - 1;
      if (v < -(1 << (AW-1)))    return -(1 << (AW-1));
      return v;
`else
      logic signed [AW-1:0] t;
      t = AW'(v);
      return int'(t);
`endif
   endfunction

   function automatic logic [N_OUT*AW-1:0] model(input int xs [N_IN]);
      logic [N_OUT*AW-1:0] r;
      r = '0;
      for (int k = 0; k < N_OUT; k++) begin
         int acc;
         acc = wm[k][N_IN];
         for (int i = 0; i < N_IN; i++) acc = step(acc + wm[k][i] * xs[i]);
         if (acc < 0) acc = 0;
         r[k*AW +: AW] = AW'(acc);
      end
      return r;
   endfunction

   function automatic logic [N_IN*DW-1:0] pack_x(input int xs [N_IN]);
      logic [N_IN*DW-1:0] v;
      v = '0;
      for (int i = 0; i < N_IN; i++) v[i*DW +: DW] = DW'(xs[i]);
      return v;
   endfunction

   // All tasks start and end at a falling edge.
   task automatic wr(input int addr, input int data);
      wr_en   = 1'b1;
      wr_addr = ADW'(addr);
      wr_data = WW'(data);
      @(negedge clk);
      wr_en = 1'b0;
      if (addr < NW) wm[addr / (N_IN+1)][addr % (N_IN+1)] = data;
   endtask

   task automatic start_vec(input int xs [N_IN]);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", longint'(in_ready), 1);
      in_valid = 1'b1;
      in_vec   = pack_x(xs);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic finish_vec(input string name, input logic [N_OUT*AW-1:0] exp,
                             input int stall, input int lat0);
      int lat;
      lat = lat0;
      chk({name, "_busy"}, longint'(busy), 1);
      chk({name, "_in_ready_mac"}, longint'(in_ready), 0);
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, lat, LAT);
      chk({name, "_out_vec"}, longint'(out_vec), longint'(exp));
      if (stall > 0) begin
         out_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, longint'(out_valid), 1);
            chk({name, "_hold_vec"}, longint'(out_vec), longint'(exp));
            chk({name, "_hold_in_ready"}, longint'(in_ready), 0);
         end
         out_ready = 1'b1;
      end
      @(negedge clk);
      chk({name, "_back_idle"}, longint'(in_ready), 1);
      chk({name, "_valid_drop"}, longint'(out_valid), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tw [NW];
      int x_one [N_IN];
      int x_three [N_IN];
      int xs [N_IN];
      logic [N_OUT*AW-1:0] e;
      int sat_n;

      tw = '{4, -3, 0, 0, 0, 0, 2,
             0, 0, 1, 2, 0, 0, -2,
             1, 1, 1, 1, 1, 1, 0};
      tbl[0].x = '{1, -1, 0, 0, 0, 0};    tbl[0].exp = {8'd0,  8'd0, 8'd9};
      tbl[1].x = '{0, 0, 0, -2, -1, 0};   tbl[1].exp = {8'd0,  8'd0, 8'd2};
      tbl[2].x = '{3, 3, 3, 3, 3, 3};     tbl[2].exp = {8'd18, 8'd7, 8'd5};
      tbl[3].x = '{-4, -4, -4, -4, -4, -4}; tbl[3].exp = {8'd0, 8'd0, 8'd0};
      x_one   = '{1, 0, 0, 0, 0, 0};
      x_three = '{3, 3, 3, 3, 3, 3};
      for (int k = 0; k < N_OUT; k++)
         for (int i = 0; i <= N_IN; i++) wm[k][i] = 0;

      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_out_vec", longint'(out_vec), 0);

      for (int a = 0; a < NW; a++) wr(a, tw[a]);
      for (int t = 0; t < 4; t++) begin
         start_vec(tbl[t].x);
         finish_vec($sformatf("tbl%0d", t), tbl[t].exp, 0, 1);
      end

      // Downstream stall in DONE.
      start_vec(tbl[2].x);
      finish_vec("stall10", tbl[2].exp, 10, 1);

      // Bias write during MAC must be dropped.
      start_vec(tbl[0].x);
      wr_en = 1'b1; wr_addr = ADW'(6); wr_data = WW'(5);
      @(negedge clk);
      wr_en = 1'b0;
      finish_vec("wr_in_mac", tbl[0].exp, 0, 2);
      start_vec(tbl[0].x);
      finish_vec("after_mac_wr", tbl[0].exp, 0, 1);

      // Write and accept together: old bias used now, new bias next time.
      in_valid = 1'b1; in_vec = pack_x(tbl[0].x);
      wr_en = 1'b1; wr_addr = ADW'(6); wr_data = WW'(6);
      @(negedge clk);
      in_valid = 1'b0; wr_en = 1'b0;
      finish_vec("wr_accept_old", tbl[0].exp, 0, 1);
      wm[0][N_IN] = 6;
      start_vec(tbl[0].x);
      finish_vec("wr_accept_new", {8'd0, 8'd0, 8'd13}, 0, 1);

      // Overflow: 7 + 6*21 = 133 per neuron.
      for (int a = 0; a < NW; a++) wr(a, 7);
`ifdef ANN_LAYER_SAT_EN
      sat_n = 127;
`else
      sat_n = 0;
`endif
      e = {AW'(sat_n), AW'(sat_n), AW'(sat_n)};
      start_vec(x_three);
      finish_vec("overflow", e, 0, 1);

      // Reset after neuron 0 has been written (7 + 7 = 14 pending).
      start_vec(x_one);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", longint'(in_ready), 1);
      chk("midrst_out_valid", longint'(out_valid), 0);
      chk("midrst_busy", longint'(busy), 0);
      chk("midrst_out_vec", longint'(out_vec), 0);
      rst = 1'b0;
      for (int k = 0; k < N_OUT; k++)
         for (int i = 0; i <= N_IN; i++) wm[k][i] = 0;
      @(negedge clk);
      start_vec(x_one);
      finish_vec("midrst_weights", '0, 0, 1);

      for (int r = 0; r < 30; r++) begin
         int nwr;
         nwr = int'($urandom_range(0, 4));
         for (int w = 0; w < nwr; w++)
            wr(int'($urandom_range(0, (1 << ADW) - 1)), int'($urandom_range(0, 15)) - 8);
         for (int i = 0; i < N_IN; i++) xs[i] = int'($urandom_range(0, 7)) - 4;
         e = model(xs);
         start_vec(xs);
         finish_vec($sformatf("rand%0d", r), e, int'($urandom_range(0, 2)), 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
